// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer with valid/ready fetch handshake and buffered redirects.
// Optional PC_MISALIGN_CHECK_EN: misaligned branch/jump targets trap to EXC_VECTOR.
module pc_sequencer #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned INSTR_BYTES  = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            holdPC,
    input  logic            excReq,
    input  logic            branchReq,
    input  logic [XLEN-1:0] branchTarget,
    input  logic            jumpReq,
    input  logic [XLEN-1:0] jumpTarget,
    input  logic            imemReady,
    output logic [XLEN-1:0] outPC,
    output logic [XLEN-1:0] pcPlus,
    output logic            fetchValid,
    output logic            fetchKill,
    output logic            misalign
);

    localparam logic [XLEN-1:0] RstVec    = XLEN'(RESET_VECTOR);
    localparam logic [XLEN-1:0] ExcVec    = XLEN'(EXC_VECTOR);
    localparam logic [XLEN-1:0] StepBytes = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] AlignMask = XLEN'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {StBoot, StReq, StHold} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    logic            pend_valid_q, pend_valid_d;
    logic            pend_mis_q, pend_mis_d;
    logic            misalign_q, misalign_d;

    logic            redir_valid;
    logic            redir_mis;
    logic [XLEN-1:0] raw_target;
    logic [XLEN-1:0] redir_target;

    assign redir_valid = excReq | branchReq | jumpReq;
    assign outPC       = pc_q;
    assign pcPlus      = pc_q + StepBytes;
    assign misalign    = misalign_q;

    // Resolve the winning redirect (exc > branch > jump) to its final target.
    always_comb begin
        raw_target = branchReq ? branchTarget : jumpTarget;
        redir_mis  = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
        redir_target = raw_target;
        if (|(raw_target & AlignMask)) begin
            redir_target = ExcVec;
            redir_mis    = 1'b1;
        end
`else
        redir_target = raw_target & ~AlignMask;
`endif
        if (excReq) begin
            redir_target = ExcVec;
            redir_mis    = 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pend_mis_d    = pend_mis_q;
        misalign_d    = 1'b0;
        fetchValid    = 1'b0;
        fetchKill     = 1'b0;

        unique case (state_q)
            StBoot, StHold: begin
                if (redir_valid) begin
                    pc_d       = redir_target;
                    misalign_d = redir_mis;
                end
                state_d = holdPC ? StHold : StReq;
            end
            StReq: begin
                fetchValid = 1'b1;
                if (imemReady) begin
                    pend_valid_d = 1'b0;
                    state_d      = holdPC ? StHold : StReq;
                    if (redir_valid) begin
                        pc_d       = redir_target;
                        misalign_d = redir_mis;
                        fetchKill  = 1'b1;
                    end else if (pend_valid_q) begin
                        pc_d       = pend_target_q;
                        misalign_d = pend_mis_q;
                        fetchKill  = 1'b1;
                    end else begin
                        pc_d = pcPlus;
                    end
                end else if (redir_valid) begin
                    // Request address must stay stable until accepted; park the redirect.
                    pend_valid_d  = 1'b1;
                    pend_target_d = redir_target;
                    pend_mis_d    = redir_mis;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= StBoot;
            pc_q          <= RstVec;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            pend_mis_q    <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pend_mis_q    <= pend_mis_d;
            misalign_q    <= misalign_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random stimulus against a
// behavioural model; a second 8-bit instance shares the stimulus to cover address wrap.
module tb_pc_sequencer;

    localparam logic [31:0] EXC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        Reset;
    logic        holdPC, excReq, branchReq, jumpReq, imemReady;
    logic [31:0] branchTarget, jumpTarget;
    logic [31:0] outPC, pcPlus;
    logic        fetchValid, fetchKill, misalign;
    logic [7:0]  outPC8, pcPlus8;
    logic        fetchValid8, fetchKill8, misalign8;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: current address, whether a request is being presented, buffered redirect.
    logic [31:0] m_pc;
    logic        m_valid, m_mis;
    logic [32:0] m_pend[$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .Reset(Reset), .holdPC(holdPC), .excReq(excReq),
        .branchReq(branchReq), .branchTarget(branchTarget),
        .jumpReq(jumpReq), .jumpTarget(jumpTarget), .imemReady(imemReady),
        .outPC(outPC), .pcPlus(pcPlus), .fetchValid(fetchValid),
        .fetchKill(fetchKill), .misalign(misalign)
    );

    pc_sequencer #(.XLEN(8)) dut8 (
        .clk(clk), .Reset(Reset), .holdPC(holdPC), .excReq(excReq),
        .branchReq(branchReq), .branchTarget(branchTarget[7:0]),
        .jumpReq(jumpReq), .jumpTarget(jumpTarget[7:0]), .imemReady(imemReady),
        .outPC(outPC8), .pcPlus(pcPlus8), .fetchValid(fetchValid8),
        .fetchKill(fetchKill8), .misalign(misalign8)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_pend.delete();
    endtask

    // {misaligned, target} of the redirect that wins this cycle.
    function automatic logic [32:0] resolve();
        logic [31:0] t;
        if (excReq) return {1'b0, EXC};
        t = branchReq ? branchTarget : jumpTarget;
        if (t % 4 != 0) begin
`ifdef PC_MISALIGN_CHECK_EN
            return {1'b1, EXC};
`else
            return {1'b0, t - (t % 4)};
`endif
        end
        return {1'b0, t};
    endfunction

    // Called at a falling edge: drive, check, advance model across the rising edge.
    task automatic step(input logic h, input logic e, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt, input logic r);
        logic [32:0] rd;
        logic        has, exp_kill, nmis;
        logic [7:0]  pc8;
        holdPC = h; excReq = e; branchReq = b; branchTarget = bt;
        jumpReq = j; jumpTarget = jt; imemReady = r;
        #1;
        has      = e | b | j;
        rd       = resolve();
        exp_kill = m_valid && r && (has || m_pend.size() > 0);
        pc8      = m_pc[7:0];
        check_eq("outPC", outPC, m_pc);
        check_eq("pcPlus", pcPlus, m_pc + 32'd4);
        check_eq("fetchValid", {31'b0, fetchValid}, {31'b0, m_valid});
        check_eq("fetchKill", {31'b0, fetchKill}, {31'b0, exp_kill});
        check_eq("misalign", {31'b0, misalign}, {31'b0, m_mis});
        check_eq("outPC8", {24'b0, outPC8}, {24'b0, pc8});
        check_eq("pcPlus8", {24'b0, pcPlus8}, {24'b0, pc8 + 8'd4});
        check_eq("fetchValid8", {31'b0, fetchValid8}, {31'b0, m_valid});
        check_eq("fetchKill8", {31'b0, fetchKill8}, {31'b0, exp_kill});
        check_eq("misalign8", {31'b0, misalign8}, {31'b0, m_mis});
        @(posedge clk);
        nmis = 1'b0;
        if (m_valid) begin
            if (r) begin
                if (has) begin
                    m_pc = rd[31:0];
                    nmis = rd[32];
                end else if (m_pend.size() > 0) begin
                    m_pc = m_pend[0][31:0];
                    nmis = m_pend[0][32];
                end else begin
                    m_pc = m_pc + 32'd4;
                end
                m_pend.delete();
                m_valid = !h;
            end else if (has) begin
                m_pend.delete();
                m_pend.push_back(rd);
            end
        end else begin
            if (has) begin
                m_pc = rd[31:0];
                nmis = rd[32];
            end
            m_valid = !h;
        end
        m_mis = nmis;
        @(negedge clk);
    endtask

    task automatic idle(input logic r);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, r);
    endtask

    initial begin
        logic [31:0] bt, jt;
        Reset = 1'b1;
        holdPC = 1'b0; excReq = 1'b0; branchReq = 1'b0; jumpReq = 1'b0;
        branchTarget = 32'h0; jumpTarget = 32'h0; imemReady = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_pc", outPC, 32'h0);
        check_eq("reset_valid", {31'b0, fetchValid}, 32'h0);
        Reset = 1'b0;

        // Free run: 0, 0, 4, 8, 12 then 0x10.
        for (int i = 0; i < 5; i++) idle(1'b1);
        #1;
        check_eq("run_pc_0x10", outPC, 32'h10);

        // Backpressure with a branch arriving mid-request.
        step(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check_eq("bp_pc_stable", outPC, 32'h10);
        idle(1'b1);
        check_eq("bp_target", outPC, 32'h200);

        // Simultaneous redirects at accept.
        step(1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h500, 1'b1);
        check_eq("simul_exc", outPC, EXC);

        // Stall around 0x20 with a jump during hold.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("stall_pc", outPC, 32'h24);
        check_eq("stall_valid", {31'b0, fetchValid}, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b1);
        check_eq("hold_jump", outPC, 32'h400);
        idle(1'b1);
        check_eq("release_pc", outPC, 32'h400);
        check_eq("release_valid", {31'b0, fetchValid}, 32'h1);

        // Wrap: both widths step from ...FC to 0.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        idle(1'b1);
        check_eq("wrap32", outPC, 32'h0);
        check_eq("wrap8", {24'b0, outPC8}, 32'h0);

        // Misaligned branch.
        step(1'b0, 1'b0, 1'b1, 32'h102, 1'b0, 32'h0, 1'b1);
`ifdef PC_MISALIGN_CHECK_EN
        check_eq("misalign_pc", outPC, EXC);
        check_eq("misalign_pulse", {31'b0, misalign}, 32'h1);
`else
        check_eq("misalign_pc", outPC, 32'h100);
        check_eq("misalign_pulse", {31'b0, misalign}, 32'h0);
`endif
        idle(1'b0);

        // Asynchronous reset mid-request with a redirect buffered.
        step(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
        imemReady = 1'b1;
        #2 Reset = 1'b1;
        #1;
        check_eq("async_rst_pc", outPC, 32'h0);
        check_eq("async_rst_valid", {31'b0, fetchValid}, 32'h0);
        check_eq("async_rst_kill", {31'b0, fetchKill}, 32'h0);
        model_reset();
        @(negedge clk);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                Reset = 1'b1;
                #1;
                check_eq("rand_rst_pc", outPC, 32'h0);
                model_reset();
                @(negedge clk);
                Reset = 1'b0;
            end else begin
                bt = $urandom;
                jt = $urandom;
                if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
                if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
                if ($urandom_range(0, 7) == 0) jt[31:8] = 24'hFF_FFFF;
                step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 6) == 0, bt, $urandom_range(0, 6) == 0, jt,
                     $urandom_range(0, 9) < 7);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
